// File: rtl/mem_access_ctrl_pkg.sv
// mem_ctrl_pkg: types and constants shared by the memory-stage access
// sequencer. Holds the sequencer state encoding, the ResultSrc codes seen
// in the MEM stage, and a helper that decides whether an instruction touches
// data memory.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
   localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

   // A MEM-stage instruction needs the data memory if it is a store or a load.
   function automatic logic is_access(input logic [1:0] result_src,
                                      input logic       mem_write);
      return mem_write | (result_src == RESULT_SRC_MEM);
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: req/ack bus between the memory-stage sequencer and a
// variable-latency data memory.
//   mem_req   : request, high for the whole access
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : access address
//   mem_wdata : store data
//   mem_ack   : single-cycle completion pulse from memory
//   mem_rdata : read data, valid with mem_ack
// master = sequencer side, slave = memory side.
interface mem_access_ctrl_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/mem_access_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk : clock, rising edge
//   rst : synchronous reset, active-low
//   en  : count this cycle
//   clr : synchronous clear (wins over en)
//   q   : current count
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q
);

   // Count register: reset/clear to zero, increment until all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && (q != '1)) begin
         q <= q + W'(1);
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access sequencer for the pipelined RV32 core.
// Turns a MEM-stage load/store into a req/ack transaction on the data-memory
// bus, stalls the front of the pipeline and bubbles MEM/WB until the access
// completes, abandons hung accesses after TIMEOUT_CYCLES request cycles and
// counts stalled cycles.
//   clk, rst (sync, active-low)
//   ResultSrcM, MemWriteM, ALUResultM, WriteDataM : MEM-stage control/data
//   bus (master)        : req/ack data-memory bus
//   ReadDataM           : captured load data
//   StallF/D/E/M, FlushW: pipeline hold and MEM/WB bubble
//   mem_err, err_clr    : sticky timeout flag and its clear
//   stall_cnt           : saturating count of stalled cycles
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           ResultSrcM,
   input  logic                 MemWriteM,
   input  logic [31:0]          ALUResultM,
   input  logic [31:0]          WriteDataM,
   mem_access_ctrl_if.master    bus,
   output logic [31:0]          ReadDataM,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 StallE,
   output logic                 StallM,
   output logic                 FlushW,
   output logic                 mem_err,
   input  logic                 err_clr,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

   mem_state_t  state_r;
   logic [7:0]  timer_r;
   logic        mem_req_r;
   logic        mem_we_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;
   logic [31:0] read_data_r;
   logic        mem_err_r;
   logic        access_s;
   logic        stall_s;
   logic        timeout_s;

   assign access_s  = is_access(ResultSrcM, MemWriteM);
   // Stall is combinational so the pipeline freezes in the very cycle the
   // access is first seen in IDLE.
   assign stall_s   = ((state_r == IDLE) && access_s) || (state_r == REQ);
   assign timeout_s = (state_r == REQ) && !bus.mem_ack && (timer_r == TIMER_LAST);

   assign StallF = stall_s;
   assign StallD = stall_s;
   assign StallE = stall_s;
   assign StallM = stall_s;
   assign FlushW = stall_s;

   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign ReadDataM     = read_data_r;
   assign mem_err       = mem_err_r;

   // Sequencer FSM with its registered bus outputs, read data and timer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         timer_r     <= 8'd0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
         read_data_r <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (access_s) begin
                  state_r     <= REQ;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= MemWriteM;
                  mem_addr_r  <= ALUResultM;
                  mem_wdata_r <= WriteDataM;
                  timer_r     <= 8'd0;
               end
            end
            REQ: begin
               if (bus.mem_ack) begin
                  state_r   <= DONE;
                  mem_req_r <= 1'b0;
                  if (!mem_we_r) begin
                     read_data_r <= bus.mem_rdata;
                  end
               end else if (timer_r == TIMER_LAST) begin
                  // Hung access: give up and hand a zero to a waiting load.
                  state_r   <= DONE;
                  mem_req_r <= 1'b0;
                  if (!mem_we_r) begin
                     read_data_r <= 32'd0;
                  end
               end else begin
                  timer_r <= timer_r + 8'd1;
               end
            end
            DONE: begin
               // No fast path: the next access is picked up in IDLE.
               state_r <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               mem_req_r <= 1'b0;
            end
         endcase
      end
   end

   // Sticky timeout flag; a timeout in the same cycle as err_clr keeps it set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_err_r <= 1'b0;
      end else if (timeout_s) begin
         mem_err_r <= 1'b1;
      end else if (err_clr) begin
         mem_err_r <= 1'b0;
      end else begin
         mem_err_r <= mem_err_r;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (stall_s),
      .clr (1'b0),
      .q   (stall_cnt)
   );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed, table-driven bench for mem_access_ctrl plus
// hand-written sequences for timeout, reset and back-to-back accesses.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallF, StallD, StallE, StallM, FlushW;
   logic        mem_err;
   logic        err_clr;
   logic [31:0] stall_cnt;

   int total;
   int bad;

   mem_access_ctrl_if mif ();

   mem_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .ResultSrcM (ResultSrcM),
      .MemWriteM  (MemWriteM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .bus        (mif),
      .ReadDataM  (ReadDataM),
      .StallF     (StallF),
      .StallD     (StallD),
      .StallE     (StallE),
      .StallM     (StallM),
      .FlushW     (FlushW),
      .mem_err    (mem_err),
      .err_clr    (err_clr),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  rsrc;
      logic        mw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] rdata;
      logic        exp_req;
      logic        exp_we;
      logic        exp_stall;
      logic [31:0] exp_rdm;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] stalls();
      return {27'd0, StallF, StallD, StallE, StallM, FlushW};
   endfunction

   task automatic drive(input logic [1:0] rs, input logic mw, input logic [31:0] a,
                        input logic [31:0] wd, input logic ack, input logic [31:0] rd);
      ResultSrcM    = rs;
      MemWriteM     = mw;
      ALUResultM    = a;
      WriteDataM    = wd;
      mif.mem_ack   = ack;
      mif.mem_rdata = rd;
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;

      //            rsrc   mw    addr          wdata          ack   rdata          req   we    stall rdm            cnt
      vecs[0]  = '{2'b00, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'd0};
      vecs[1]  = '{2'b10, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'd0};
      vecs[2]  = '{2'b01, 1'b0, 32'h100,      32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         32'd0};
      vecs[3]  = '{2'b01, 1'b0, 32'h100,      32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0,         32'd1};
      vecs[4]  = '{2'b01, 1'b0, 32'h100,      32'h0,         1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 1'b1, 32'h0,         32'd2};
      vecs[5]  = '{2'b01, 1'b0, 32'h100,      32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hDEADBEEF,  32'd3};
      vecs[6]  = '{2'b00, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hDEADBEEF,  32'd3};
      vecs[7]  = '{2'b00, 1'b1, 32'h200,      32'h12345678,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEADBEEF,  32'd3};
      vecs[8]  = '{2'b00, 1'b1, 32'h200,      32'h12345678,  1'b1, 32'hAAAA5555,  1'b1, 1'b1, 1'b1, 32'hDEADBEEF,  32'd4};
      vecs[9]  = '{2'b00, 1'b1, 32'h200,      32'h12345678,  1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hDEADBEEF,  32'd5};
      vecs[10] = '{2'b00, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hDEADBEEF,  32'd5};
      vecs[11] = '{2'b10, 1'b0, 32'h0,        32'h0,         1'b1, 32'h00000055,  1'b0, 1'b1, 1'b0, 32'hDEADBEEF,  32'd5};
      vecs[12] = '{2'b00, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hDEADBEEF,  32'd5};

      // Reset state
      rst = 1'b0;
      err_clr = 1'b0;
      drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      tick();
      chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
      chk("rst_addr", mif.mem_addr, 32'd0);
      chk("rst_rdm", ReadDataM, 32'd0);
      chk("rst_cnt", stall_cnt, 32'd0);
      rst = 1'b1;

      // Ten cycles of non-memory instructions
      for (int i = 0; i < 10; i++) begin
         drive((i % 2 == 0) ? 2'b00 : 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
         #1;
         chk("idle_stall", stalls(), 32'd0);
         chk("idle_req", {31'd0, mif.mem_req}, 32'd0);
         tick();
      end
      chk("idle_cnt", stall_cnt, 32'd0);

      // Table: load with ack latency 2, store with ack latency 1, stray ack
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].rsrc, vecs[i].mw, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rdata);
         #1;
         chk($sformatf("v%0d_req", i), {31'd0, mif.mem_req}, {31'd0, vecs[i].exp_req});
         chk($sformatf("v%0d_we", i), {31'd0, mif.mem_we}, {31'd0, vecs[i].exp_we});
         chk($sformatf("v%0d_stall", i), stalls(), vecs[i].exp_stall ? 32'h1F : 32'h0);
         chk($sformatf("v%0d_rdm", i), ReadDataM, vecs[i].exp_rdm);
         chk($sformatf("v%0d_cnt", i), stall_cnt, vecs[i].exp_cnt);
         if (vecs[i].exp_req) begin
            chk($sformatf("v%0d_addr", i), mif.mem_addr, vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), mif.mem_wdata, vecs[i].wdata);
         end
         tick();
      end

      // Timeout: load with no ack
      drive(2'b01, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
      tick();
      n = 0;
      while (mif.mem_req && n < 40) begin
         n++;
         tick();
      end
      chk("to_req_cycles", n, 32'd16);
      chk("to_rdm", ReadDataM, 32'd0);
      chk("to_err", {31'd0, mem_err}, 32'd1);
      chk("to_done_stall", stalls(), 32'd0);
      drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      tick();
      drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'h00000077);
      tick();
      drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("late_ack_rdm", ReadDataM, 32'd0);
      chk("late_ack_req", {31'd0, mif.mem_req}, 32'd0);
      chk("late_ack_stall", stalls(), 32'd0);
      chk("err_held", {31'd0, mem_err}, 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", {31'd0, mem_err}, 32'd0);

      // Timeout with err_clr held high: set wins
      drive(2'b01, 1'b0, 32'h304, 32'h0, 1'b0, 32'h0);
      err_clr = 1'b1;
      tick();
      n = 0;
      while (mif.mem_req && n < 40) begin
         n++;
         tick();
      end
      err_clr = 1'b0;
      chk("to2_req_cycles", n, 32'd16);
      chk("to2_set_wins", {31'd0, mem_err}, 32'd1);
      drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();

      // Back-to-back loads 0x10 then 0x14, ack latency 1
      drive(2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
      #1;
      chk("b2b_a_detect", stalls(), 32'h1F);
      tick();
      drive(2'b01, 1'b0, 32'h10, 32'h0, 1'b1, 32'hA1A1A1A1);
      #1;
      chk("b2b_a_req", {31'd0, mif.mem_req}, 32'd1);
      chk("b2b_a_addr", mif.mem_addr, 32'h10);
      tick();
      drive(2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
      #1;
      chk("b2b_a_done_req", {31'd0, mif.mem_req}, 32'd0);
      chk("b2b_a_rdm", ReadDataM, 32'hA1A1A1A1);
      chk("b2b_a_done_stall", stalls(), 32'd0);
      tick();
      drive(2'b01, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0);
      #1;
      chk("b2b_b_idle_req", {31'd0, mif.mem_req}, 32'd0);
      chk("b2b_b_detect", stalls(), 32'h1F);
      tick();
      drive(2'b01, 1'b0, 32'h14, 32'h0, 1'b1, 32'hB2B2B2B2);
      #1;
      chk("b2b_b_req", {31'd0, mif.mem_req}, 32'd1);
      chk("b2b_b_addr", mif.mem_addr, 32'h14);
      chk("b2b_b_rdm_old", ReadDataM, 32'hA1A1A1A1);
      tick();
      drive(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      chk("b2b_b_rdm", ReadDataM, 32'hB2B2B2B2);
      tick();

      // Reset during the third REQ cycle of a store
      drive(2'b00, 1'b1, 32'h400, 32'hCAFE0001, 1'b0, 32'h0);
      tick();
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rstm_req_before", {31'd0, mif.mem_req}, 32'd1);
      chk("rstm_we_before", {31'd0, mif.mem_we}, 32'd1);
      tick();
      chk("rstm_req", {31'd0, mif.mem_req}, 32'd0);
      chk("rstm_we", {31'd0, mif.mem_we}, 32'd0);
      chk("rstm_addr", mif.mem_addr, 32'd0);
      chk("rstm_wdata", mif.mem_wdata, 32'd0);
      chk("rstm_rdm", ReadDataM, 32'd0);
      chk("rstm_err", {31'd0, mem_err}, 32'd0);
      chk("rstm_cnt", stall_cnt, 32'd0);
      chk("rstm_stall_idle", stalls(), 32'h1F);
      rst = 1'b1;
      tick();
      chk("rstm_reissue_req", {31'd0, mif.mem_req}, 32'd1);
      chk("rstm_reissue_addr", mif.mem_addr, 32'h400);
      chk("rstm_reissue_wdata", mif.mem_wdata, 32'hCAFE0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage access sequencer for the pipelined RV32 core. It sits beside the EX/MEM register.
- Takes the MEM-stage control and data (ResultSrcM, MemWriteM, ALUResultM, WriteDataM).
- Runs a req/ack handshake with a variable-latency data memory.
- Holds the front of the pipeline and bubbles MEM/WB until the access completes.
- Detects hung accesses with a timeout and counts memory stall cycles for performance analysis.

Parameters:
- TIMEOUT_CYCLES, 16: REQ cycles without ack before the access is abandoned (legal range 2..255).
- CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- ResultSrcM  in  2  MEM-stage result select; 2'b01 = load
- MemWriteM  in  1  MEM-stage store
- ALUResultM  in  32  access address
- WriteDataM  in  32  store data
- mem_req  out  1  request to data memory
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  registered address
- mem_wdata  out  32  registered store data
- mem_ack  in  1  memory completion, single-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ack
- ReadDataM  out  32  captured load data to the writeback mux
- StallF, StallD, StallE, StallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers
- FlushW  out  1  load a bubble into MEM/WB
- mem_err  out  1  sticky timeout flag
- err_clr  in  1  clears mem_err
- stall_cnt  out  CNT_W  saturating count of cycles with StallM=1

Behaviour:
- Access: access = MemWriteM | (ResultSrcM == 2'b01).
- States: IDLE, REQ, DONE. Transitions:
  - IDLE: access=1 → REQ. On that edge, capture mem_addr<=ALUResultM, mem_wdata<=WriteDataM, mem_we<=MemWriteM, mem_req<=1, and clear the timeout counter.
  - IDLE: access=0 → stay in IDLE, no stall.
  - REQ: mem_ack=1 → DONE. mem_req<=0; for a read, ReadDataM<=mem_rdata.
  - REQ: no ack and timer == TIMEOUT_CYCLES-1 → DONE. mem_req<=0, ReadDataM<=0, mem_err<=1.
  - REQ: otherwise → stay in REQ; timer increments.
  - DONE: → IDLE unconditionally. The MEM instruction advances to WB at the end of this cycle.
- Stall = (state==IDLE & access) | (state==REQ). This is combinational from the inputs and state.
- StallF = StallD = StallE = StallM = FlushW = Stall.
- Minimum memory-op occupancy is 3 cycles (IDLE detect, REQ with ack in its first cycle, DONE). Ack latency L≥1 REQ cycles gives L+2 cycles.
- mem_addr, mem_wdata and mem_we stay stable for the whole REQ period. mem_req is registered and high only in REQ.
- mem_ack in IDLE or DONE is ignored: no state change and ReadDataM is unchanged. A late ack after a timeout is therefore dropped.
- ReadDataM holds its value until the next read completes or times out. Stores leave it unchanged.
- Back-to-back accesses: the next access is detected in IDLE, the cycle after DONE. There is no fast-path from DONE.
- mem_err:
  - set on timeout; err_clr clears it;
  - if set and clear occur in the same cycle, set wins;
  - a timeout does not otherwise alter pipeline flow.
- stall_cnt increments each cycle Stall=1 and saturates at all-ones. There is no wrap.
- Reset (rst=0 at an edge), including mid-REQ:
  - state←IDLE;
  - mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, mem_err and stall_cnt all ←0;
  - the timer ←0;
  - mem_req drops on that same edge.
- During reset, Stall follows the combinational formula with state=IDLE.

Decomposition:
- Package mem_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
  - localparam RESULT_SRC_MEM = 2'b01;
  - localparam RESULT_SRC_ALU = 2'b00;
  - localparam RESULT_SRC_PC4 = 2'b10.
- One sub-module, sat_counter (parameter W; ports clk, rst, en, clr, q), provides stall_cnt. The timeout timer stays inline.

Test Plan:
- ResultSrcM=01, ALUResultM=0x100, ack 2 cycles after mem_req rises with rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0, Stall high 3 cycles, ReadDataM=0xDEADBEEF in DONE, stall_cnt=3.
- MemWriteM=1, addr 0x200, data 0x12345678, ack in first REQ cycle → mem_we=1, mem_wdata=0x12345678 stable through REQ, Stall high 2 cycles, ReadDataM unchanged.
- ResultSrcM=00 or 10 with MemWriteM=0 for 10 cycles → mem_req=0, Stall=0 throughout, stall_cnt=0.
- Load with no ack, TIMEOUT_CYCLES=16 → mem_req high exactly 16 cycles, then DONE with ReadDataM=0 and mem_err=1. An ack arriving 2 cycles later is ignored. err_clr=1 → mem_err=0 next cycle.
- rst=0 during the 3rd REQ cycle → next edge gives mem_req=0, state IDLE, all outputs 0. After rst=1 with access still present → new request issued.
- Two consecutive loads (addr 0x10 then 0x14), ack latency 1 → two distinct mem_req pulses separated by DONE and IDLE cycles, each ReadDataM captured in order.
